pwm_multi_channel: RTL and testbench
====================================

// Module: pwm_multi_channel
// PURPOSE
//   Consumer end of the fade interface: converts NUM_CH duty values (pwm_value-style,
//   0..PWM_INTERVAL) into registered PWM waveforms driving the board LEDs.
//   Duty updates are double-buffered and commit only at a period boundary, so outputs never glitch.
//   Channels may be phase-staggered to spread LED current across the period.
// PARAMETERS
//   PWM_INTERVAL   1200  period in clk cycles (100us at 12MHz)
//   NUM_CH         3     number of PWM channels
//   PHASE_STAGGER  1     1: channel i offset by i*(PWM_INTERVAL/NUM_CH) cycles; 0: all channels aligned
// PORTS
//   clk           in   1           system clock, 12MHz
//   rst           in   1           synchronous, active-high reset
//   en            in   1           1: run; 0: freeze counter, force outputs low
//   duty_in       in   NUM_CH*W    W=$clog2(PWM_INTERVAL)+1; channel i at [i*W +: W]
//   duty_load     in   1           1-cycle strobe: capture duty_in into the pending buffer
//   duty_ack      out  1           1-cycle pulse: pending duties committed to active
//   period_start  out  1           1-cycle pulse: counter wrapped to 0
//   pwm_out       out  NUM_CH      PWM waveforms, registered
// BEHAVIOUR
//   - Reset: cnt=0, active[i]=0, pending empty, pwm_out=0, duty_ack=0, period_start=0.
//     Reset mid-period discards any pending load; no ack follows.
//   - cnt counts 0..PWM_INTERVAL-1 and wraps; it advances only when en=1.
//   - Boundary edge = clock edge with en=1 and cnt==PWM_INTERVAL-1. On that edge:
//     cnt<=0, period_start<=1; if pending or duty_load: active<=new duties, duty_ack<=1, pending cleared.
//   - duty_load on any edge: pending<=duty_in, pending flag set. A later load before the
//     boundary overwrites the earlier one (last wins). Exactly one ack per boundary.
//   - duty_load on the boundary edge itself: duty_in commits directly on that edge (bypass).
//   - Load accepted while en=0: held in pending; commits at the first boundary after en returns.
//   - phase_i = (cnt + i*OFS) mod PWM_INTERVAL; OFS = PHASE_STAGGER ? PWM_INTERVAL/NUM_CH : 0.
//     The modulo is a compare-and-subtract, with no divider.
//   - pwm_out[i] <= en & (phase_i < active[i]), using pre-edge cnt and active values.
//     Latency is 1 cycle: the first cycle driven by new duties is the cycle after cnt==0.
//   - duty 0: output always low. duty >= PWM_INTERVAL: output always high (no clamp needed;
//     the compare saturates naturally).
//   - en=0: pwm_out=0 on the next edge, cnt holds its value, no boundary, no ack,
//     no period_start. On en=1, the count resumes from the held cnt.
//   - duty_ack and period_start are registered and high for exactly one cycle. They coincide
//     whenever a commit occurs.
// TESTING  (PWM_INTERVAL=8, NUM_CH=2, PHASE_STAGGER=1, OFS=4)
//   1. rst 3 cycles, en=1, no loads -> pwm_out=00 throughout; period_start every 8 cycles;
//      duty_ack never asserts.
//   2. load {3,3} at cnt=2 -> no output change until the boundary; duty_ack and
//      period_start both high in cycle cnt==0.
//      Then ch0 is high for 3 cycles starting the cycle after cnt==0, and ch1 is high for
//      the 3 cycles following cnt==4,5,6.
//   3. load {1,1} at cnt=1, then {5,5} at cnt=5 in the same period -> a single duty_ack;
//      both channels run at duty 5/8.
//   4. duties {0,8}, then {7,9} -> ch0 always low and ch1 always high; then ch0 is high
//      7 of 8 cycles and ch1 is always high.
//   5. duty {4,4} running, en=0 at cnt=3, load {2,2}, en=1 after 10 cycles -> pwm_out=0 and
//      cnt frozen during en=0. After en=1, cnt resumes at 3; ack and the commit of 2/8 occur
//      at the next wrap.
//   6. load {6,6} at cnt=4, rst at cnt=6 -> all outputs 0 after rst; no duty_ack at any
//      later boundary; active duties stay 0.

Source files
------------

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator with double-buffered duty updates that commit only at the period
// boundary, and optional per-channel phase stagger to spread LED current across the period.
module pwm_multi_channel #(
   parameter int PWM_INTERVAL  = 1200,
   parameter int NUM_CH        = 3,
   parameter bit PHASE_STAGGER = 1'b1,
   localparam int W            = $clog2(PWM_INTERVAL) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [NUM_CH*W-1:0] duty_in,
   input  logic              duty_load,
   output logic              duty_ack,
   output logic              period_start,
   output logic [NUM_CH-1:0] pwm_out
);

   localparam int OFS = PHASE_STAGGER ? PWM_INTERVAL / NUM_CH : 0;
   localparam logic [W-1:0] LAST = W'(PWM_INTERVAL - 1);
   localparam logic [W:0] PERIOD = (W + 1)'(PWM_INTERVAL);

   // Handshake: duty_load is a one-cycle strobe that is always accepted (no ready);
   // duty_ack pulses once on the boundary edge that moves the newest load into active.
   logic [W-1:0]          cnt_q, cnt_d;
   logic [NUM_CH*W-1:0]   active_q, active_d;
   logic [NUM_CH*W-1:0]   pending_q, pending_d;
   logic                  pend_valid_q, pend_valid_d;
   logic [NUM_CH-1:0]     pwm_q, pwm_d;
   logic                  ack_q, ack_d;
   logic                  ps_q, ps_d;
   logic                  boundary;
   logic [W:0]            phase;

   always_comb begin
      boundary     = en && (cnt_q == LAST);
      cnt_d        = cnt_q;
      active_d     = active_q;
      pending_d    = duty_load ? duty_in : pending_q;
      pend_valid_d = duty_load | pend_valid_q;
      ack_d        = 1'b0;
      ps_d         = boundary;

      if (boundary) begin
         cnt_d = '0;
         // A load on the boundary edge bypasses the pending buffer.
         if (duty_load) begin
            active_d     = duty_in;
            ack_d        = 1'b1;
            pend_valid_d = 1'b0;
         end else if (pend_valid_q) begin
            active_d     = pending_q;
            ack_d        = 1'b1;
            pend_valid_d = 1'b0;
         end
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_comb begin
      phase = '0;
      pwm_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         // Offset is below one period, so a single conditional subtract wraps it.
         phase = {1'b0, cnt_q} + (W + 1)'(i * OFS);
         if (phase >= PERIOD) begin
            phase = phase - PERIOD;
         end
         pwm_d[i] = en & (phase < {1'b0, active_q[i*W +: W]});
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         active_q     <= '0;
         pending_q    <= '0;
         pend_valid_q <= 1'b0;
         pwm_q        <= '0;
         ack_q        <= 1'b0;
         ps_q         <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         active_q     <= active_d;
         pending_q    <= pending_d;
         pend_valid_q <= pend_valid_d;
         pwm_q        <= pwm_d;
         ack_q        <= ack_d;
         ps_q         <= ps_d;
      end
   end

   assign pwm_out      = pwm_q;
   assign duty_ack     = ack_q;
   assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel at PWM_INTERVAL=8, NUM_CH=2, stagger on: a per-cycle reference
// model plus duty-table vectors and directed sequences for enable, reload and reset corners.
module tb_pwm_multi_channel;

   localparam int P   = 8;
   localparam int NCH = 2;
   localparam int W   = 4;
   localparam int OFS = 4;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               en = 1'b0;
   logic               duty_load = 1'b0;
   logic [NCH*W-1:0]   duty_in = '0;
   logic               duty_ack;
   logic               period_start;
   logic [NCH-1:0]     pwm_out;

   pwm_multi_channel #(
      .PWM_INTERVAL (P),
      .NUM_CH       (NCH),
      .PHASE_STAGGER(1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .duty_in     (duty_in),
      .duty_load   (duty_load),
      .duty_ack    (duty_ack),
      .period_start(period_start),
      .pwm_out     (pwm_out)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: period position, active duties and a queue of loads awaiting commit.
   int               m_cnt = 0;
   int               m_act[NCH];
   logic [NCH*W-1:0] pend_q[$];
   logic [NCH-1:0]   exp_pwm;
   logic             exp_ack;
   logic             exp_ps;
   int               ack_seen = 0;
   int               ps_seen = 0;
   int               hi[NCH];

   always @(posedge clk) begin
      logic [NCH*W-1:0] newest;
      if (rst) begin
         m_cnt = 0;
         for (int i = 0; i < NCH; i++) m_act[i] = 0;
         pend_q.delete();
         exp_pwm = '0;
         exp_ack = 1'b0;
         exp_ps  = 1'b0;
      end else begin
         for (int i = 0; i < NCH; i++)
            exp_pwm[i] = en && (((m_cnt + i * OFS) % P) < m_act[i]);
         exp_ps  = en && (m_cnt == P - 1);
         exp_ack = 1'b0;
         if (duty_load) pend_q.push_back(duty_in);
         if (exp_ps) begin
            m_cnt = 0;
            if (pend_q.size() > 0) begin
               newest = pend_q[pend_q.size() - 1];
               for (int i = 0; i < NCH; i++) m_act[i] = int'(newest[i*W +: W]);
               pend_q.delete();
               exp_ack = 1'b1;
            end
         end else if (en) begin
            m_cnt = m_cnt + 1;
         end
      end
      #1;
      check("pwm_out", 32'(pwm_out), 32'(exp_pwm));
      check("duty_ack", 32'(duty_ack), 32'(exp_ack));
      check("period_start", 32'(period_start), 32'(exp_ps));
      ack_seen += int'(duty_ack);
      ps_seen  += int'(period_start);
      for (int i = 0; i < NCH; i++) hi[i] += int'(pwm_out[i]);
   end

   task automatic clear_counts();
      ack_seen = 0;
      ps_seen  = 0;
      for (int i = 0; i < NCH; i++) hi[i] = 0;
   endtask

   task automatic wait_cnt(input int k);
      int n = 0;
      while (m_cnt != k && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("wait_cnt", 32'(m_cnt), 32'(k));
   endtask

   task automatic apply_load(input int d0, input int d1);
      duty_in   = {W'(d1), W'(d0)};
      duty_load = 1'b1;
      @(negedge clk);
      duty_load = 1'b0;
   endtask

   task automatic wait_ack(output int n);
      logic found = 1'b0;
      n = 0;
      while (!found && n < 40) begin
         @(negedge clk);
         n++;
         found = duty_ack;
      end
      check("ack_arrives", 32'(found), 32'd1);
      check("ack_with_period_start", 32'(period_start), 32'd1);
   endtask

   task automatic measure(input string name, input int e0, input int e1);
      clear_counts();
      repeat (P) @(negedge clk);
      check({name, "_ch0_high"}, 32'(hi[0]), 32'(e0));
      check({name, "_ch1_high"}, 32'(hi[1]), 32'(e1));
   endtask

   typedef struct {
      int d0;
      int d1;
      int h0;
      int h1;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int n;
      vecs[0] = '{d0: 3,  d1: 3, h0: 3, h1: 3};
      vecs[1] = '{d0: 0,  d1: 8, h0: 0, h1: 8};
      vecs[2] = '{d0: 7,  d1: 9, h0: 7, h1: 8};
      vecs[3] = '{d0: 1,  d1: 6, h0: 1, h1: 6};
      vecs[4] = '{d0: 15, d1: 0, h0: 8, h1: 0};
      vecs[5] = '{d0: 2,  d1: 5, h0: 2, h1: 5};
      for (int i = 0; i < NCH; i++) hi[i] = 0;

      // Reset, then run idle: periodic period_start, no ack, outputs low.
      repeat (3) @(negedge clk);
      rst = 1'b0;
      en  = 1'b1;
      clear_counts();
      repeat (3 * P) @(negedge clk);
      check("idle_period_starts", 32'(ps_seen), 32'd3);
      check("idle_acks", 32'(ack_seen), 32'd0);
      check("idle_ch0_high", 32'(hi[0]), 32'd0);
      check("idle_ch1_high", 32'(hi[1]), 32'd0);

      // Duty table: load mid-period, wait for commit, measure one steady period.
      for (int v = 0; v < 6; v++) begin
         wait_cnt(2);
         apply_load(vecs[v].d0, vecs[v].d1);
         wait_ack(n);
         repeat (P) @(negedge clk);
         measure($sformatf("vec%0d", v), vecs[v].h0, vecs[v].h1);
      end

      // Two loads in one period: last wins, one ack.
      wait_cnt(1);
      clear_counts();
      apply_load(1, 1);
      wait_cnt(5);
      apply_load(5, 5);
      wait_cnt(1);
      check("double_load_acks", 32'(ack_seen), 32'd1);
      repeat (P) @(negedge clk);
      measure("last_wins", 5, 5);

      // Enable freeze with a load held pending until the next wrap.
      wait_cnt(2);
      apply_load(4, 4);
      wait_ack(n);
      wait_cnt(3);
      en = 1'b0;
      apply_load(2, 2);
      clear_counts();
      repeat (9) @(negedge clk);
      check("frozen_ch0_high", 32'(hi[0]), 32'd0);
      check("frozen_ch1_high", 32'(hi[1]), 32'd0);
      check("frozen_period_starts", 32'(ps_seen), 32'd0);
      check("frozen_acks", 32'(ack_seen), 32'd0);
      en = 1'b1;
      wait_ack(n);
      check("resume_cycles_to_ack", 32'(n), 32'd5);
      repeat (P) @(negedge clk);
      measure("after_resume", 2, 2);

      // Reset mid-period discards the pending load.
      wait_cnt(4);
      apply_load(6, 6);
      wait_cnt(6);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      clear_counts();
      repeat (3 * P) @(negedge clk);
      check("post_rst_acks", 32'(ack_seen), 32'd0);
      check("post_rst_period_starts", 32'(ps_seen), 32'd3);
      check("post_rst_ch0_high", 32'(hi[0]), 32'd0);
      check("post_rst_ch1_high", 32'(hi[1]), 32'd0);

      // Random traffic, checked cycle by cycle against the model.
      for (int c = 0; c < 400; c++) begin
         en        = ($urandom_range(0, 9) != 0);
         duty_load = ($urandom_range(0, 5) == 0);
         duty_in   = NCH*W'($urandom);
         rst       = ($urandom_range(0, 99) == 0);
         @(negedge clk);
      end
      rst       = 1'b0;
      duty_load = 1'b0;
      en        = 1'b1;
      repeat (2 * P) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
